// File: rtl/tank_shell.sv
// tank_shell: single-shell projectile controller for one tank. Launches a shell from the
// tank muzzle on a fire-key edge, advances it once per frame along the latched direction,
// then runs explosion and cooldown phases before another launch is allowed.
module tank_shell #(
  parameter int unsigned SHELL_STEP      = 4,
  parameter int unsigned MUZZLE_OFFSET   = 8,
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = 639,
  parameter int unsigned Y_MIN           = 0,
  parameter int unsigned Y_MAX           = 479,
  parameter int unsigned EXPLODE_FRAMES  = 8,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic       hit_in,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic       ShellActive,
  output logic       Exploding,
  output logic [1:0] Facing,
  output logic       Ready
);

  typedef enum logic [1:0] {StIdle, StFlight, StExplode, StCooldown} state_e;

  localparam logic [7:0] KeyW    = 8'h1A;
  localparam logic [7:0] KeyA    = 8'h04;
  localparam logic [7:0] KeyS    = 8'h16;
  localparam logic [7:0] KeyD    = 8'h07;
  localparam logic [7:0] KeyFire = 8'h2C;

  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirRight = 2'b01;
  localparam logic [1:0] DirDown  = 2'b10;
  localparam logic [1:0] DirLeft  = 2'b11;

  // All position arithmetic is 11 bits wide so no 10-bit wrap can reach the outputs.
  localparam logic [10:0] Step = 11'(SHELL_STEP);
  localparam logic [10:0] Ofs  = 11'(MUZZLE_OFFSET);
  localparam logic [10:0] XLo  = 11'(X_MIN);
  localparam logic [10:0] XHi  = 11'(X_MAX);
  localparam logic [10:0] YLo  = 11'(Y_MIN);
  localparam logic [10:0] YHi  = 11'(Y_MAX);

  localparam logic [7:0] ExplodeLast  = 8'(EXPLODE_FRAMES - 1);
  localparam logic [7:0] CooldownLast = 8'(COOLDOWN_FRAMES - 1);

  state_e      state;
  logic [1:0]  dir;
  logic [7:0]  phase_cnt;
  logic [7:0]  prev_keycode;
  logic        fire_edge;
  logic [10:0] spawn_x, spawn_y;
  logic [10:0] next_x, next_y;
  logic        at_bound;

  // Fire is a rising edge of the space key; holding it produces a single edge.
  assign fire_edge = (keycode == KeyFire) && (prev_keycode != KeyFire);

  // Muzzle position: tank position pushed out along the current facing, saturated to bounds.
  always_comb begin
    spawn_x = {1'b0, TankX};
    spawn_y = {1'b0, TankY};
    unique case (Facing)
      DirUp:    spawn_y = (spawn_y < YLo + Ofs) ? YLo : spawn_y - Ofs;
      DirRight: spawn_x = spawn_x + Ofs;
      DirDown:  spawn_y = spawn_y + Ofs;
      DirLeft:  spawn_x = (spawn_x < XLo + Ofs) ? XLo : spawn_x - Ofs;
    endcase
    if (spawn_x > XHi) spawn_x = XHi;
    else if (spawn_x < XLo) spawn_x = XLo;
    if (spawn_y > YHi) spawn_y = YHi;
    else if (spawn_y < YLo) spawn_y = YLo;
  end

  // Next in-flight position; a step that would leave the field clamps to the violated bound.
  always_comb begin
    next_x   = {1'b0, ShellX};
    next_y   = {1'b0, ShellY};
    at_bound = 1'b0;
    unique case (dir)
      DirUp: begin
        if (next_y < YLo + Step) begin
          next_y   = YLo;
          at_bound = 1'b1;
        end else begin
          next_y = next_y - Step;
        end
      end
      DirRight: begin
        if (next_x + Step > XHi) begin
          next_x   = XHi;
          at_bound = 1'b1;
        end else begin
          next_x = next_x + Step;
        end
      end
      DirDown: begin
        if (next_y + Step > YHi) begin
          next_y   = YHi;
          at_bound = 1'b1;
        end else begin
          next_y = next_y + Step;
        end
      end
      DirLeft: begin
        if (next_x < XLo + Step) begin
          next_x   = XLo;
          at_bound = 1'b1;
        end else begin
          next_x = next_x - Step;
        end
      end
    endcase
  end

  // Shell FSM with registered status outputs; facing and key history track every frame.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= StIdle;
      dir          <= DirUp;
      phase_cnt    <= 8'd0;
      prev_keycode <= 8'd0;
      Facing       <= DirUp;
      ShellX       <= 10'd0;
      ShellY       <= 10'd0;
      ShellActive  <= 1'b0;
      Exploding    <= 1'b0;
      Ready        <= 1'b1;
    end else begin
      prev_keycode <= keycode;
      case (keycode)
        KeyW:    Facing <= DirUp;
        KeyD:    Facing <= DirRight;
        KeyS:    Facing <= DirDown;
        KeyA:    Facing <= DirLeft;
        default: Facing <= Facing;
      endcase

      case (state)
        StIdle: begin
          if (fire_edge) begin
            state       <= StFlight;
            dir         <= Facing;
            ShellX      <= spawn_x[9:0];
            ShellY      <= spawn_y[9:0];
            ShellActive <= 1'b1;
            Ready       <= 1'b0;
          end
        end
        StFlight: begin
          // A hit wins over the bound clamp and freezes the shell where it is.
          if (hit_in || at_bound) begin
            state       <= StExplode;
            phase_cnt   <= 8'd0;
            ShellActive <= 1'b0;
            Exploding   <= 1'b1;
          end
          if (!hit_in) begin
            ShellX <= next_x[9:0];
            ShellY <= next_y[9:0];
          end
        end
        StExplode: begin
          if (phase_cnt == ExplodeLast) begin
            state     <= StCooldown;
            phase_cnt <= 8'd0;
            Exploding <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        StCooldown: begin
          if (phase_cnt == CooldownLast) begin
            state     <= StIdle;
            phase_cnt <= 8'd0;
            Ready     <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_shell.sv
`timescale 1ns/1ps
module tb_tank_shell;

  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] TankX, TankY;
  logic       hit_in;
  logic [9:0] ShellX, ShellY;
  logic       ShellActive, Exploding, Ready;
  logic [1:0] Facing;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       expl;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t obs;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign obs = {ShellX, ShellY, ShellActive, Exploding, Ready};

  tank_shell dut (
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .TankX      (TankX),
    .TankY      (TankY),
    .hit_in     (hit_in),
    .ShellX     (ShellX),
    .ShellY     (ShellY),
    .ShellActive(ShellActive),
    .Exploding  (Exploding),
    .Facing     (Facing),
    .Ready      (Ready)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic exp_t mk(int x, int y, bit a, bit ex, bit r);
    exp_t t;
    t.x = 10'(x); t.y = 10'(y); t.act = a; t.expl = ex; t.rdy = r;
    return t;
  endfunction

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic pulse_reset;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; keycode = 8'h00; hit_in = 1'b0; TankX = 10'd0; TankY = 10'd0;
    sb.push_back(mk(0, 0, 0, 0, 1));
    #3;
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e || Facing !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_state: got x=%0d y=%0d act=%b expl=%b rdy=%b fac=%b want x=%0d y=%0d act=%b expl=%b rdy=%b fac=00",
               obs.x, obs.y, obs.act, obs.expl, obs.rdy, Facing, e.x, e.y, e.act, e.expl, e.rdy);
    end
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  task automatic test_fire_right;
    keycode = 8'h07;
    tick();
    n_cmp++;
    if (Facing !== 2'b01) begin
      n_bad++;
      $display("FAIL facing_d: got %b want 01", Facing);
    end
    keycode = 8'h00;
    tick();
    TankX = 10'd350; TankY = 10'd400; keycode = 8'h2C;
    sb.push_back(mk(358, 400, 1, 0, 0));
    sb.push_back(mk(362, 400, 1, 0, 0));
    sb.push_back(mk(366, 400, 1, 0, 0));
    sb.push_back(mk(366, 400, 0, 1, 0));
    for (int f = 0; f < 4; f++) begin
      // After launch: turn to W and move the tank; the shell must not care.
      if (f == 1) begin keycode = 8'h1A; TankX = 10'd10; TankY = 10'd5; end
      if (f == 2) keycode = 8'h00;
      if (f == 3) hit_in = 1'b1;
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL fire_right[%0d]: got x=%0d y=%0d act=%b expl=%b rdy=%b want x=%0d y=%0d act=%b expl=%b rdy=%b",
                 f, obs.x, obs.y, obs.act, obs.expl, obs.rdy, e.x, e.y, e.act, e.expl, e.rdy);
      end
      if (f == 1) begin
        n_cmp++;
        if (Facing !== 2'b00) begin
          n_bad++;
          $display("FAIL facing_midflight: got %b want 00", Facing);
        end
      end
    end
    hit_in = 1'b0;
    pulse_reset();
  endtask

  task automatic test_up_cooldown;
    keycode = 8'h1A;
    tick();
    keycode = 8'h00;
    tick();
    TankX = 10'd100; TankY = 10'd20; keycode = 8'h2C;
    sb.push_back(mk(100, 12, 1, 0, 0));
    tick();
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL up_launch: got x=%0d y=%0d act=%b expl=%b rdy=%b want x=%0d y=%0d act=%b expl=%b rdy=%b",
               obs.x, obs.y, obs.act, obs.expl, obs.rdy, e.x, e.y, e.act, e.expl, e.rdy);
    end
    keycode = 8'h00;
    // Frames 0-2 flight, 3-10 explode, 11-40 cooldown, 41-42 idle.
    for (int f = 0; f < 43; f++) begin
      if (f < 3)       sb.push_back(mk(100, 8 - 4 * f, 1, 0, 0));
      else if (f < 11) sb.push_back(mk(100, 0, 0, 1, 0));
      else if (f < 41) sb.push_back(mk(100, 0, 0, 0, 0));
      else             sb.push_back(mk(100, 0, 0, 0, 1));
    end
    for (int f = 0; f < 43; f++) begin
      // Hammer fire edges through cooldown; none may be remembered into IDLE.
      if (f >= 11) keycode = (f % 2 == 1) ? 8'h2C : 8'h00;
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL up_cooldown[%0d]: got x=%0d y=%0d act=%b expl=%b rdy=%b want x=%0d y=%0d act=%b expl=%b rdy=%b",
                 f, obs.x, obs.y, obs.act, obs.expl, obs.rdy, e.x, e.y, e.act, e.expl, e.rdy);
      end
    end
    keycode = 8'h00;
    pulse_reset();
  endtask

  task automatic test_hold_fire;
    TankX = 10'd300; TankY = 10'd240;
    // 0-58 flight, 59-66 explode, 67-96 cooldown, 97-102 idle, 103 relaunch.
    for (int f = 0; f < 104; f++) begin
      if (f < 59)       sb.push_back(mk(300, 232 - 4 * f, 1, 0, 0));
      else if (f < 67)  sb.push_back(mk(300, 0, 0, 1, 0));
      else if (f < 97)  sb.push_back(mk(300, 0, 0, 0, 0));
      else if (f < 103) sb.push_back(mk(300, 0, 0, 0, 1));
      else              sb.push_back(mk(300, 232, 1, 0, 0));
    end
    for (int f = 0; f < 104; f++) begin
      keycode = (f == 102) ? 8'h00 : 8'h2C;
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL hold_fire[%0d]: got x=%0d y=%0d act=%b expl=%b rdy=%b want x=%0d y=%0d act=%b expl=%b rdy=%b",
                 f, obs.x, obs.y, obs.act, obs.expl, obs.rdy, e.x, e.y, e.act, e.expl, e.rdy);
      end
    end
    keycode = 8'h00;
    pulse_reset();
  endtask

  task automatic test_hit_vs_clamp;
    for (int r = 0; r < 2; r++) begin
      keycode = 8'h07;
      tick();
      keycode = 8'h00;
      tick();
      TankX = 10'd629; TankY = 10'd100; keycode = 8'h2C;
      sb.push_back(mk(637, 100, 1, 0, 0));
      sb.push_back(mk((r == 0) ? 637 : 639, 100, 0, 1, 0));
      for (int f = 0; f < 2; f++) begin
        if (f == 1) begin keycode = 8'h00; hit_in = (r == 0); end
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL hit_vs_clamp[%0d.%0d]: got x=%0d y=%0d act=%b expl=%b rdy=%b want x=%0d y=%0d act=%b expl=%b rdy=%b",
                   r, f, obs.x, obs.y, obs.act, obs.expl, obs.rdy, e.x, e.y, e.act, e.expl, e.rdy);
        end
      end
      hit_in = 1'b0;
      pulse_reset();
    end
  endtask

  task automatic test_reset_explode;
    TankX = 10'd200; TankY = 10'd200; keycode = 8'h2C;
    sb.push_back(mk(200, 192, 1, 0, 0));
    sb.push_back(mk(200, 192, 0, 1, 0));
    sb.push_back(mk(200, 192, 0, 1, 0));
    sb.push_back(mk(200, 192, 0, 1, 0));
    for (int f = 0; f < 4; f++) begin
      if (f == 1) begin keycode = 8'h00; hit_in = 1'b1; end
      if (f == 2) begin keycode = 8'h07; hit_in = 1'b0; end
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL rst_explode[%0d]: got x=%0d y=%0d act=%b expl=%b rdy=%b want x=%0d y=%0d act=%b expl=%b rdy=%b",
                 f, obs.x, obs.y, obs.act, obs.expl, obs.rdy, e.x, e.y, e.act, e.expl, e.rdy);
      end
    end
    // Third explode frame is showing; reset between edges must clear everything at once.
    keycode = 8'h00;
    Reset = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 1));
    #2;
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e || Facing !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_async: got x=%0d y=%0d act=%b expl=%b rdy=%b fac=%b want x=%0d y=%0d act=%b expl=%b rdy=%b fac=00",
               obs.x, obs.y, obs.act, obs.expl, obs.rdy, Facing, e.x, e.y, e.act, e.expl, e.rdy);
    end
    Reset = 1'b0;
    TankX = 10'd50; TankY = 10'd60; keycode = 8'h2C;
    sb.push_back(mk(50, 52, 1, 0, 0));
    tick();
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL rst_relaunch: got x=%0d y=%0d act=%b expl=%b rdy=%b want x=%0d y=%0d act=%b expl=%b rdy=%b",
               obs.x, obs.y, obs.act, obs.expl, obs.rdy, e.x, e.y, e.act, e.expl, e.rdy);
    end
    keycode = 8'h00;
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_fire_right();
    test_up_cooldown();
    test_hold_fire();
    test_hit_vs_clamp();
    test_reset_explode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
